// File: rtl/rvv_backend_uop_queue_pkg.sv
// Shared types and sizing for the backend uop queue.
// UOP_QUEUE_t is the entry format carried from decode to dispatch.
package rvv_backend_uop_queue_pkg;

  typedef struct packed {
    logic [31:0] uop_pc;
    logic [5:0]  uop_funct6;
    logic [2:0]  uop_funct3;
    logic [4:0]  vd_index;
    logic [4:0]  vs1_index;
    logic [4:0]  vs2_index;
    logic [2:0]  uop_index;
  } UOP_QUEUE_t;

  localparam int UQ_WIDTH     = $bits(UOP_QUEUE_t);
  localparam int UQ_DEPTH     = 8;
  localparam int UQ_PTR_WIDTH = 3;
  localparam int UQ_PORTS     = 4;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rvv_backend_uop_queue_if.sv
// Decode-side push bus, status flags and dispatch-side read/pop bus.
// master = decode/dispatch side, slave = the queue.
interface rvv_backend_uop_queue_if
  import rvv_backend_uop_queue_pkg::*;
#(
  parameter int DWIDTH = UQ_WIDTH
);
  logic              push0, push1, push2, push3;
  logic [DWIDTH-1:0] data0, data1, data2, data3;
  logic              fifo_full;
  logic              fifo_1left_to_full;
  logic              fifo_2left_to_full;
  logic              fifo_3left_to_full;
  logic              fifo_empty;
  logic              pop0, pop1;
  logic              rd_valid0, rd_valid1;
  logic [DWIDTH-1:0] rd_data0, rd_data1;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push0, push1, push2, push3, data0, data1, data2, data3, pop0, pop1,
    input  fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    input  fifo_empty, rd_valid0, rd_valid1, rd_data0, rd_data1,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  push0, push1, push2, push3, data0, data1, data2, data3, pop0, pop1,
    output fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    output fifo_empty, rd_valid0, rd_valid1, rd_data0, rd_data1,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/uq_push_compact.sv
// Maps each set push port to its compacted write offset (number of set
// lower-numbered ports) and reports the total number of pushes.
module uq_push_compact
  import rvv_backend_uop_queue_pkg::*;
(
  input  logic [3:0]      push,
  output logic [3:0][1:0] offset,
  output logic [2:0]      npush
);

  generate
    for (genvar gi = 0; gi < UQ_PORTS; gi++) begin : g_off
      localparam logic [3:0] LOWER_MASK = 4'((1 << gi) - 1);
      assign offset[gi] = 2'(popcount4(push & LOWER_MASK));
    end
  endgenerate

  assign npush = popcount4(push);

endmodule

// File: rtl/rvv_backend_uop_queue.sv
// Four-write, two-read FWFT uop queue between decode and dispatch.
// Rejected push groups / pop requests leave state untouched and pulse an error.
module rvv_backend_uop_queue
  import rvv_backend_uop_queue_pkg::*;
#(
  parameter  int DEPTH  = UQ_DEPTH,
  parameter  int DWIDTH = UQ_WIDTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst,
  rvv_backend_uop_queue_if.slave uq
);

  localparam int CW = PTR_W + 1;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [3:0]                   push_vec;
  logic [3:0][DWIDTH-1:0]       data_vec;
  logic [3:0][1:0]              offset;
  logic [2:0]                   npush;
  logic [3:0][PTR_W-1:0]        waddr;
  logic [CW-1:0]                free;
  logic                         push_ok;
  logic                         pop_illegal;
  logic                         pop_ok;
  logic [1:0]                   npop;
  logic [PTR_W-1:0]             raddr1;

  assign push_vec = {uq.push3, uq.push2, uq.push1, uq.push0};
  assign data_vec = {uq.data3, uq.data2, uq.data1, uq.data0};

  uq_push_compact u_compact (
    .push   (push_vec),
    .offset (offset),
    .npush  (npush)
  );

  // Admission uses the pre-pop count: freed slots are not reusable this cycle.
  assign free        = CW'(DEPTH) - count_q;
  assign push_ok     = (CW'(npush) <= free);
  assign pop_illegal = (uq.pop1 & ~uq.pop0)
                     | (uq.pop0 & (count_q == '0))
                     | (uq.pop1 & (count_q < CW'(2)));
  assign pop_ok      = uq.pop0 & ~pop_illegal;
  assign npop        = pop_ok ? (uq.pop1 ? 2'd2 : 2'd1) : 2'd0;

  generate
    for (genvar gi = 0; gi < UQ_PORTS; gi++) begin : g_waddr
      assign waddr[gi] = wptr_q + PTR_W'(offset[gi]);
    end
  endgenerate

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (push_ok) begin
      wptr_d  = wptr_q + PTR_W'(npush);
      count_d = count_q + CW'(npush);
    end else begin
      overflow_d = 1'b1;
    end
    if (pop_illegal) begin
      underflow_d = 1'b1;
    end
    rptr_d  = rptr_q + PTR_W'(npop);
    count_d = count_d - CW'(npop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      for (int i = 0; i < UQ_PORTS; i++) begin
        if (push_vec[i]) begin
          mem[waddr[i]] <= data_vec[i];
        end
      end
    end
  end

  assign raddr1       = rptr_q + PTR_W'(1);
  assign uq.rd_valid0 = (count_q != '0);
  assign uq.rd_valid1 = (count_q >= CW'(2));
  assign uq.rd_data0  = uq.rd_valid0 ? mem[rptr_q] : '0;
  assign uq.rd_data1  = uq.rd_valid1 ? mem[raddr1] : '0;

  assign uq.fifo_empty         = (count_q == '0);
  assign uq.fifo_full          = (free == CW'(0));
  assign uq.fifo_1left_to_full = (free == CW'(1));
  assign uq.fifo_2left_to_full = (free == CW'(2));
  assign uq.fifo_3left_to_full = (free == CW'(3));
  assign uq.overflow_err       = overflow_q;
  assign uq.underflow_err      = underflow_q;

  always @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CW'(DEPTH) && wptr_q == PTR_W'(rptr_q + PTR_W'(count_q)));
    end
  end

endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// Directed bench: the driver queues expected pop data, a negedge monitor
// compares every popped uop; status/error flags are checked inline.
module tb_rvv_backend_uop_queue;
  import rvv_backend_uop_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvv_backend_uop_queue_if #(.DWIDTH(UQ_WIDTH)) uq ();

  rvv_backend_uop_queue #(.DEPTH(UQ_DEPTH), .DWIDTH(UQ_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .uq  (uq)
  );

  UOP_QUEUE_t exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  bit illegal_pop = 1'b0;
  UOP_QUEUE_t z = '0;

  function automatic UOP_QUEUE_t mk(input int tag);
    UOP_QUEUE_t u;
    u.uop_pc     = 32'h8000_0000 + 32'(tag * 4);
    u.uop_funct6 = 6'(tag);
    u.uop_funct3 = 3'(tag);
    u.vd_index   = 5'(tag + 1);
    u.vs1_index  = 5'(tag + 2);
    u.vs2_index  = 5'(tag + 3);
    u.uop_index  = 3'(tag);
    return u;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input bit e, input bit f,
                            input bit l1, input bit l2, input bit l3);
    chk({tag, ".empty"}, 64'(uq.fifo_empty), 64'(e));
    chk({tag, ".full"},  64'(uq.fifo_full), 64'(f));
    chk({tag, ".1left"}, 64'(uq.fifo_1left_to_full), 64'(l1));
    chk({tag, ".2left"}, 64'(uq.fifo_2left_to_full), 64'(l2));
    chk({tag, ".3left"}, 64'(uq.fifo_3left_to_full), 64'(l3));
  endtask

  // One clock of stimulus; accepted pushes are queued as expected pop data.
  task automatic drive(input logic [3:0] p, input UOP_QUEUE_t d0, input UOP_QUEUE_t d1,
                       input UOP_QUEUE_t d2, input UOP_QUEUE_t d3,
                       input logic p0, input logic p1, input bit accept);
    UOP_QUEUE_t d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (p[i]) exp_q.push_back(d[i]);
      end
    end
    uq.push0 = p[0]; uq.push1 = p[1]; uq.push2 = p[2]; uq.push3 = p[3];
    uq.data0 = d0; uq.data1 = d1; uq.data2 = d2; uq.data3 = d3;
    uq.pop0 = p0; uq.pop1 = p1;
    @(posedge clk);
    #1;
    uq.push0 = 1'b0; uq.push1 = 1'b0; uq.push2 = 1'b0; uq.push3 = 1'b0;
    uq.pop0 = 1'b0; uq.pop1 = 1'b0;
  endtask

  task automatic pop2();
    drive(4'b0000, z, z, z, z, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uq.pop0 && !illegal_pop) begin
        chk("pop0.valid", 64'(uq.rd_valid0), 64'd1);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pop0.data: got %0h expected none", uq.rd_data0);
        end else begin
          UOP_QUEUE_t e;
          e = exp_q.pop_front();
          $display("pop0 %0h exp %0h", uq.rd_data0, e);
          chk("pop0.data", 64'(uq.rd_data0), 64'(e));
        end
        if (uq.pop1) begin
          chk("pop1.valid", 64'(uq.rd_valid1), 64'd1);
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL pop1.data: got %0h expected none", uq.rd_data1);
          end else begin
            UOP_QUEUE_t e;
            e = exp_q.pop_front();
            $display("pop1 %0h exp %0h", uq.rd_data1, e);
            chk("pop1.data", 64'(uq.rd_data1), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    uq.push0 = 1'b0; uq.push1 = 1'b0; uq.push2 = 1'b0; uq.push3 = 1'b0;
    uq.data0 = '0; uq.data1 = '0; uq.data2 = '0; uq.data3 = '0;
    uq.pop0 = 1'b0; uq.pop1 = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_status("reset", 1, 0, 0, 0, 0);
    chk("reset.rd_valid0", 64'(uq.rd_valid0), 64'd0);
    chk("reset.rd_valid1", 64'(uq.rd_valid1), 64'd0);
    chk("reset.rd_data0", 64'(uq.rd_data0), 64'd0);
    chk("reset.rd_data1", 64'(uq.rd_data1), 64'd0);
    chk("reset.ovf", 64'(uq.overflow_err), 64'd0);
    chk("reset.unf", 64'(uq.underflow_err), 64'd0);

    // Fill with two 4-wide pushes, then drain in pairs.
    drive(4'b1111, mk(0), mk(1), mk(2), mk(3), 0, 0, 1);
    chk("fill.rd_data0", 64'(uq.rd_data0), 64'(mk(0)));
    drive(4'b1111, mk(4), mk(5), mk(6), mk(7), 0, 0, 1);
    chk_status("fill", 0, 1, 0, 0, 0);
    repeat (4) pop2();
    chk_status("drain", 1, 0, 0, 0, 0);

    // Near-full ladder.
    drive(4'b1111, mk(8), mk(9), mk(10), mk(11), 0, 0, 1);
    drive(4'b0001, mk(12), z, z, z, 0, 0, 1);
    chk_status("nf5", 0, 0, 0, 0, 1);
    drive(4'b0010, z, mk(13), z, z, 0, 0, 1);
    chk_status("nf6", 0, 0, 0, 1, 0);
    drive(4'b1000, z, z, z, mk(14), 0, 0, 1);
    chk_status("nf7", 0, 0, 1, 0, 0);
    drive(4'b0100, z, z, mk(15), z, 0, 0, 1);
    chk_status("nf8", 0, 1, 0, 0, 0);
    repeat (4) pop2();
    chk_status("nf.drain", 1, 0, 0, 0, 0);

    // Overflow at count=6: group dropped, concurrent pop still accepted.
    drive(4'b1111, mk(16), mk(17), mk(18), mk(19), 0, 0, 1);
    drive(4'b0011, mk(20), mk(21), z, z, 0, 0, 1);
    chk_status("ovf.pre", 0, 0, 0, 1, 0);
    drive(4'b0111, mk(22), mk(23), mk(24), z, 0, 0, 0);
    chk("ovf.err", 64'(uq.overflow_err), 64'd1);
    chk_status("ovf.hold", 0, 0, 0, 1, 0);
    drive(4'b0111, mk(22), mk(23), mk(24), z, 1, 0, 0);
    chk("ovf.err2", 64'(uq.overflow_err), 64'd1);
    chk_status("ovf.pop", 0, 0, 0, 0, 1);
    drive(4'b0000, z, z, z, z, 0, 0, 1);
    chk("ovf.clear", 64'(uq.overflow_err), 64'd0);
    pop2();
    pop2();
    drive(4'b0000, z, z, z, z, 1, 0, 1);
    chk_status("ovf.drain", 1, 0, 0, 0, 0);

    // Sparse push at pointer 6 then wrap through 0..3.
    drive(4'b1010, z, mk(30), z, mk(31), 0, 0, 1);
    chk("sparse.rd_data0", 64'(uq.rd_data0), 64'(mk(30)));
    chk("sparse.rd_data1", 64'(uq.rd_data1), 64'(mk(31)));
    drive(4'b1111, mk(32), mk(33), mk(34), mk(35), 0, 0, 1);
    chk_status("wrap6", 0, 0, 0, 1, 0);
    repeat (3) pop2();
    chk_status("wrap.drain", 1, 0, 0, 0, 0);

    // Concurrent push/pop, then illegal pops.
    drive(4'b0001, mk(40), z, z, z, 0, 0, 1);
    chk("one.rd_valid1", 64'(uq.rd_valid1), 64'd0);
    chk("one.rd_data1", 64'(uq.rd_data1), 64'd0);
    drive(4'b1111, mk(41), mk(42), mk(43), mk(44), 1, 0, 1);
    chk("conc.rd_data0", 64'(uq.rd_data0), 64'(mk(41)));
    chk_status("conc", 0, 0, 0, 0, 0);
    drive(4'b0000, z, z, z, z, 0, 1, 1);
    chk("pop1only.unf", 64'(uq.underflow_err), 64'd1);
    chk("pop1only.rd_data0", 64'(uq.rd_data0), 64'(mk(41)));
    drive(4'b0000, z, z, z, z, 0, 0, 1);
    chk("unf.clear", 64'(uq.underflow_err), 64'd0);
    pop2();
    pop2();
    illegal_pop = 1'b1;
    drive(4'b0000, z, z, z, z, 1, 0, 1);
    illegal_pop = 1'b0;
    chk("emptypop.unf", 64'(uq.underflow_err), 64'd1);
    chk_status("emptypop", 1, 0, 0, 0, 0);

    // Reset mid-operation discards entries; pushes during reset ignored.
    drive(4'b1111, mk(50), mk(51), mk(52), mk(53), 0, 0, 1);
    rst = 1'b1;
    drive(4'b1111, mk(54), mk(55), mk(56), mk(57), 0, 0, 0);
    rst = 1'b0;
    exp_q.delete();
    chk_status("midrst", 1, 0, 0, 0, 0);
    chk("midrst.rd_valid0", 64'(uq.rd_valid0), 64'd0);
    drive(4'b0000, z, z, z, z, 0, 0, 1);
    chk_status("midrst.idle", 1, 0, 0, 0, 0);

    chk("scoreboard.left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvv_backend_uop_queue.md
Name: rvv_backend_uop_queue

Overview:
- Multi-write, dual-read FIFO between the decode controller and the uop dispatch stage.
- Accepts up to 4 uops per cycle on push0..3/data0..3 and exports exact near-full status (full, 1/2/3 left) that the decode controller uses to gate pushes.
- Presents the two oldest uops first-word-fall-through for dispatch, which pops 0, 1 or 2 per cycle.

Parameters:
- DEPTH, 8, number of uop entries; power of two, >= 4.
- DWIDTH, `UQ_WIDTH, bit width of one UOP_QUEUE_t entry.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- push0..push3  in  1 each  write enables; port i writes data i.
- data0..data3  in  DWIDTH each  uops to write (UOP_QUEUE_t).
- fifo_full  out  1  free entries == 0.
- fifo_1left_to_full  out  1  free entries == 1.
- fifo_2left_to_full  out  1  free entries == 2.
- fifo_3left_to_full  out  1  free entries == 3.
- fifo_empty  out  1  count == 0.
- pop0  in  1  dispatch consumes the oldest entry.
- pop1  in  1  dispatch consumes the second-oldest entry; legal only with pop0.
- rd_valid0  out  1  count >= 1.
- rd_data0  out  DWIDTH  oldest entry.
- rd_valid1  out  1  count >= 2.
- rd_data1  out  DWIDTH  second-oldest entry.
- overflow_err  out  1  registered one-cycle pulse; push group rejected.
- underflow_err  out  1  registered one-cycle pulse; illegal pop rejected.

Behaviour:
- Reset (rst high at posedge): wptr=0, rptr=0, count=0. Next cycle: fifo_empty=1, fifo_full=0, all Nleft=0, rd_valid0/1=0, rd_data0/1=0, overflow_err=0, underflow_err=0. Storage is not reset.
- Reset mid-operation discards all entries. Pushes and pops in the reset cycle are ignored.
- State: count is PTR_W+1 bits. wptr and rptr are PTR_W bits and wrap modulo DEPTH.
- Status outputs are combinational from registered count only: free = DEPTH - count. Exactly one of full/1left/2left/3left is high when free <= 3; all are low when free >= 4.
- Write, push accounting:
  - npush = popcount(push0..3).
  - Set ports are written in ascending port order to wptr, wptr+1, ... (compacted). Gaps in the push vector, e.g. 4'b0101, write 2 consecutive entries.
  - wptr += npush.
- Write, overflow: if npush > free (pre-pop count), the entire push group is dropped, no entry is written, and overflow_err pulses next cycle. Pops in the same cycle still proceed.
- Space freed by pops is not reusable in the same cycle (no pop-to-push bypass), so status latency is exactly 1 cycle.
- Read:
  - rd_data0 = mem[rptr], rd_data1 = mem[rptr+1 mod DEPTH]; combinational mux from storage.
  - Each rd_data is forced to 0 when its rd_valid is low.
  - A pushed uop is visible on rd_data the cycle after the push; there is no push-to-read bypass, even when empty.
- Pop accounting: npop = pop0 + pop1.
- Pop, illegal cases: pop1 without pop0, pop0 while count==0, or pop1 while count<2. The whole pop request is ignored and underflow_err pulses next cycle. Pushes still proceed.
- Simultaneous accepted push and pop: count_next = count + npush - npop. rptr and wptr update independently.
- Wrap-around: a 4-uop push with wptr=DEPTH-2 writes entries DEPTH-2, DEPTH-1, 0, 1. A pop1 with rptr=DEPTH-1 moves rptr to 1.
- Invariant, assertion-checked: 0 <= count <= DEPTH, and wptr == (rptr + count) mod DEPTH.

Decomposition:
- rvv_backend.svh holds UOP_QUEUE_t, `UQ_WIDTH, and new `UQ_DEPTH (8) and `UQ_PTR_WIDTH (3).
- Sub-module uq_push_compact: a combinational 4-in prefix-count that maps push port i to write offset 0..3 and outputs npush.
- Pointer/count registers and the storage array stay in the top module.

Test Plan:
- Reset then idle: after rst, fifo_empty=1, rd_valid0=0, rd_data0=0, all Nleft/full=0.
- Fill and drain:
  - 4-wide pushes A0..A3 then B0..B3 -> fifo_full=1, count=8.
  - pop0+pop1 four times -> A0,A1,A2,A3,B0,B1,B2,B3 in order; then fifo_empty=1.
- Near-full flags: push 5 entries -> fifo_3left_to_full=1. Push 1 -> fifo_2left_to_full=1. Push 1 -> 1left. Push 1 -> full.
- Overflow: count=6, push 4'b0111 -> nothing written, overflow_err=1 for one cycle, count stays 6; a simultaneous pop0 still yields count=5.
- Sparse push and wrap: rptr=wptr=6, count=0, push 4'b1010 with data1=X, data3=Y -> mem[6]=X, mem[7]=Y. Then push 4'b1111 -> entries at 0..3. Pops return X, Y, then the 4 in order.
- Concurrent push/pop and illegal pop:
  - count=1: pop0 with 4 pushes -> count=4, rd_data0 = first new entry next cycle.
  - pop1 alone -> ignored, underflow_err pulses for one cycle.
